// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Also imported by other front-panel input conditioning blocks.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'b00,
    CONFIRM_HIGH = 2'b01,
    IDLE_HIGH    = 2'b10,
    CONFIRM_LOW  = 2'b11
  } debounce_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sync_chain.sv
// N-flop asynchronous-reset synchronizer for a single asynchronous pin.
// Output resets to 0 and follows d after STAGES clock edges.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer plus stability-count FSM.
// Define DEBOUNCE_ACTIVE_LOW_EN for buttons that pull the pin low when pressed.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic bounce_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end

  logic btn_in;
  logic btn_s;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign btn_in = ~btn_raw;
`else
  assign btn_in = btn_raw;
`endif

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  debounce_state_t  state;
  debounce_state_t  state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_clean <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_clean <= clean_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = btn_clean;
    case (state)
      IDLE_LOW: begin
        if (btn_s) begin
          if (SINGLE) begin
            state_nxt = IDLE_HIGH;
            clean_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CONFIRM_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      CONFIRM_HIGH: begin
        if (!btn_s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          clean_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!btn_s) begin
          if (SINGLE) begin
            state_nxt = IDLE_LOW;
            clean_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CONFIRM_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      CONFIRM_LOW: begin
        if (btn_s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          clean_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        clean_nxt = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bounce_busy = 1'b0;
    if (state == CONFIRM_HIGH || state == CONFIRM_LOW) begin
      bounce_busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4 and =1).
// Expected per-edge outputs are queued as stimulus is driven.
module tb_button_debouncer;

  localparam int DC = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw;
  logic btn_raw1;
  logic btn_clean;
  logic bounce_busy;
  logic clean1;
  logic busy1;

  typedef struct packed {
    logic clean;
    logic busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_clean   (btn_clean),
    .bounce_busy (bounce_busy)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (1),
    .SYNC_STAGES     (SS)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw1),
    .btn_clean   (clean1),
    .bounce_busy (busy1)
  );

  function automatic logic pin(input logic pressed);
`ifdef DEBOUNCE_ACTIVE_LOW_EN
    return ~pressed;
`else
    return pressed;
`endif
  endfunction

  task automatic apply(input logic r, input logic c, input logic b);
    btn_raw = pin(r);
    sb.push_back('{clean: c, busy: b});
    @(posedge clk);
    #1;
  endtask

  task automatic apply1(input logic r, input logic c, input logic b);
    btn_raw1 = pin(r);
    sb.push_back('{clean: c, busy: b});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      btn_raw  = pin(i[0]);
      btn_raw1 = pin(i[0]);
      @(posedge clk);
      #1;
      checks++;
      if (btn_clean !== 1'b0 || bounce_busy !== 1'b0 ||
          clean1 !== 1'b0 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc %0d: clean=%b busy=%b c1=%b b1=%b expected all 0",
                 i, btn_clean, bounce_busy, clean1, busy1);
      end
    end
    btn_raw  = pin(1'b0);
    btn_raw1 = pin(1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL reset_idle edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_clean_press();
    string r = "11111111";
    string c = "00000111";
    string b = "00111000";
    for (int i = 0; i < r.len(); i++) begin
      apply(r[i] == "1", c[i] == "1", b[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL press edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_release();
    string r = "00000000";
    string c = "11111000";
    string b = "00111000";
    for (int i = 0; i < r.len(); i++) begin
      apply(r[i] == "1", c[i] == "1", b[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL release edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_glitch();
    string r = "11100000";
    string c = "00000000";
    string b = "00111000";
    for (int i = 0; i < r.len(); i++) begin
      apply(r[i] == "1", c[i] == "1", b[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL glitch edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_bounce();
    string r = "10110111111111";
    string c = "00000000001111";
    string b = "00101101110000";
    for (int i = 0; i < r.len(); i++) begin
      apply(r[i] == "1", c[i] == "1", b[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL bounce edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_min_cycles();
    string r = "11110000";
    string c = "00111100";
    string b = "00000000";
    for (int i = 0; i < r.len(); i++) begin
      apply1(r[i] == "1", c[i] == "1", b[i] == "1");
      e = sb.pop_front();
      checks++;
      if (clean1 !== e.clean || busy1 !== e.busy) begin
        failures++;
        $display("FAIL min_cycles edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, clean1, busy1, e.clean, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_confirm();
    string r0 = "1111";
    string c0 = "0000";
    string b0 = "0011";
    string r1 = "11111111";
    string c1 = "00000111";
    string b1 = "00111000";
    for (int i = 0; i < r0.len(); i++) begin
      apply(r0[i] == "1", c0[i] == "1", b0[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL mid_pre edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (btn_clean !== 1'b0 || bounce_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: clean=%b busy=%b expected clean=0 busy=0",
               btn_clean, bounce_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (btn_clean !== 1'b0 || bounce_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold: clean=%b busy=%b expected clean=0 busy=0",
               btn_clean, bounce_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < r1.len(); i++) begin
      apply(r1[i] == "1", c1[i] == "1", b1[i] == "1");
      e = sb.pop_front();
      checks++;
      if (btn_clean !== e.clean || bounce_busy !== e.busy) begin
        failures++;
        $display("FAIL mid_restart edge %0d: clean=%b busy=%b expected clean=%b busy=%b",
                 i + 1, btn_clean, bounce_busy, e.clean, e.busy);
      end
    end
  endtask

  initial begin
    btn_raw  = pin(1'b0);
    btn_raw1 = pin(1'b0);
    reset    = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_bounce();
    test_release();
    test_min_cycles();
    test_reset_mid_confirm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
